// File: rtl/reg_ex_mem.sv
// EX->MEM pipeline register with a two-entry skid buffer. Both handshake
// outputs decode from registered state, so MEM can stall without a combinational path back into EX.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held; t_mem_valid=0
// ST_BUSY  | main entry held; one more instruction accepted
// ST_FULL  | main + skid held; f_ex_ready=0
module reg_ex_mem #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_ex_valid,
  output logic              f_ex_ready,
  input  logic [DATA_W-1:0] f_ex_pc,
  input  logic [DATA_W-1:0] f_ex_alu,
  input  logic [DATA_W-1:0] f_ex_store,
  input  logic [CTRL_W-1:0] f_ex_control,
  input  logic [4:0]        f_ex_reg_addr,
  input  logic              flush,
  output logic              t_mem_valid,
  input  logic              t_mem_ready,
  output logic [DATA_W-1:0] t_mem_pc,
  output logic [DATA_W-1:0] t_mem_alu,
  output logic [DATA_W-1:0] t_mem_store,
  output logic [CTRL_W-1:0] t_mem_control,
  output logic [4:0]        t_mem_reg_addr,
  output logic [CNT_W-1:0]  t_stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic in_fire;
  logic out_fire;
  logic load_main;
  logic load_skid;
  logic skid_to_main;

  logic [DATA_W-1:0] main_pc, main_alu, main_store;
  logic [CTRL_W-1:0] main_control;
  logic [4:0]        main_reg_addr;
  logic [DATA_W-1:0] skid_pc, skid_alu, skid_store;
  logic [CTRL_W-1:0] skid_control;
  logic [4:0]        skid_reg_addr;

  assign f_ex_ready  = (state_q != ST_FULL);
  assign t_mem_valid = (state_q != ST_EMPTY);
  assign in_fire     = f_ex_valid & f_ex_ready;
  assign out_fire    = t_mem_valid & t_mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Flush overrides every transfer: incoming data is dropped and the
  // outgoing entry is treated as killed rather than delivered.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_d   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = ST_FULL;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            skid_to_main = 1'b1;
            state_d      = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // On flush only the control bundles are cleared; the rest of the payload
  // is left as-is since t_mem_valid already marks it dead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_pc       <= '0;
      main_alu      <= '0;
      main_store    <= '0;
      main_control  <= '0;
      main_reg_addr <= '0;
      skid_pc       <= '0;
      skid_alu      <= '0;
      skid_store    <= '0;
      skid_control  <= '0;
      skid_reg_addr <= '0;
    end else if (flush) begin
      main_control <= '0;
      skid_control <= '0;
    end else begin
      if (load_main) begin
        main_pc       <= f_ex_pc;
        main_alu      <= f_ex_alu;
        main_store    <= f_ex_store;
        main_control  <= f_ex_control;
        main_reg_addr <= f_ex_reg_addr;
      end else if (skid_to_main) begin
        main_pc       <= skid_pc;
        main_alu      <= skid_alu;
        main_store    <= skid_store;
        main_control  <= skid_control;
        main_reg_addr <= skid_reg_addr;
      end
      if (load_skid) begin
        skid_pc       <= f_ex_pc;
        skid_alu      <= f_ex_alu;
        skid_store    <= f_ex_store;
        skid_control  <= f_ex_control;
        skid_reg_addr <= f_ex_reg_addr;
      end
    end
  end

  assign t_mem_pc       = main_pc;
  assign t_mem_alu      = main_alu;
  assign t_mem_store    = main_store;
  assign t_mem_control  = main_control;
  assign t_mem_reg_addr = main_reg_addr;

  // Stall counter runs independently of flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_stall_cnt <= '0;
    end else if (t_mem_valid && !t_mem_ready && (t_stall_cnt != {CNT_W{1'b1}})) begin
      t_stall_cnt <= t_stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/reg_ex_mem.md
# reg_ex_mem

Pipeline register between the execute (EX) and memory-access (MEM) stages of the RISC-V core. It captures the ALU result, store data, PC, control bits and destination register from EX, then presents them to MEM. A two-entry skid buffer with valid/ready handshakes on both sides lets MEM stall without a combinational ready path back into EX. It also supports a synchronous flush and counts MEM stall cycles for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of pc / ALU result / store data
- CTRL_W, 8, width of control bundle (bit 0 = reg write enable, bit 1 = mem read, bit 2 = mem write)
- CNT_W, 16, width of stall counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- f_ex_valid  input  1  EX presents a valid instruction
- f_ex_ready  output  1  block can accept from EX
- f_ex_pc  input  DATA_W  instruction PC
- f_ex_alu  input  DATA_W  ALU result / memory address
- f_ex_store  input  DATA_W  store data (forwarded rs2)
- f_ex_control  input  CTRL_W  control bundle
- f_ex_reg_addr  input  5  destination register
- flush  input  1  kill all held instructions
- t_mem_valid  output  1  output entry valid
- t_mem_ready  input  1  MEM accepts the output entry
- t_mem_pc, t_mem_alu, t_mem_store  output  DATA_W  registered payload
- t_mem_control  output  CTRL_W  registered control
- t_mem_reg_addr  output  5  registered destination
- t_stall_cnt  output  CNT_W  saturating count of MEM stall cycles

## Operation
- Storage: main entry (drives all t_mem_* payload outputs) and skid entry.
- Fires: in_fire = f_ex_valid & f_ex_ready; out_fire = t_mem_valid & t_mem_ready.
- States: EMPTY (0 entries), BUSY (main only), FULL (main + skid).
- EMPTY: in_fire -> load main, go BUSY.
- BUSY:
  - in_fire & out_fire -> load main, stay BUSY.
  - in_fire & !out_fire -> load skid, go FULL.
  - !in_fire & out_fire -> go EMPTY.
  - Neither -> hold.
- FULL: f_ex_ready=0, so in_fire cannot occur; out_fire -> main<=skid, go BUSY; otherwise hold.
- f_ex_ready = (state != FULL) and t_mem_valid = (state != EMPTY). Both decode from registered state only; no combinational path from t_mem_ready or f_ex_valid.
- flush (synchronous, highest priority):
  - State goes to EMPTY.
  - Same-cycle in_fire is discarded.
  - main and skid control are cleared to 0; other payload fields hold.
- Payload is never modified in flight; MEM sees exactly what EX presented, in order.
- t_stall_cnt increments when t_mem_valid & !t_mem_ready, saturates at 2^CNT_W-1, and is unaffected by flush. Reset is the only clear.

## Timing
- Reset (async, while rst=1):
  - State EMPTY; all payload outputs and t_stall_cnt are 0.
  - t_mem_valid=0, f_ex_ready=1.
- Latency: in_fire at edge N puts the data on t_mem_* with t_mem_valid=1 after edge N.
- Throughput: one instruction per cycle while t_mem_ready=1.
- Stall absorption:
  - When t_mem_ready drops, one further in-flight instruction is absorbed into skid.
  - f_ex_ready goes low the cycle after the skid load.
- Simultaneous flush and out_fire: flush wins; the entry counts as killed, not transferred.
- Reset asserted mid-operation: contents are dropped immediately; no partial transfer.
- Output payload is stable while t_mem_valid=1 and t_mem_ready=0.

## Test plan
- Reset: assert rst mid-stream -> t_mem_valid=0, f_ex_ready=1, all t_mem_* = 0, t_stall_cnt=0 immediately, without waiting for a clock edge.
- Streaming: 8 back-to-back instructions with f_ex_alu=0x100..0x107 and t_mem_ready=1 -> each appears one cycle later in order, f_ex_ready stays 1, t_stall_cnt=0.
- Stall and skid:
  - Stimulus: hold t_mem_ready=0 while sending pc=0x10 then 0x14.
  - State: FULL; f_ex_ready=0; t_mem_pc=0x10 held stable.
  - Release t_mem_ready: MEM receives 0x10 then 0x14; f_ex_ready returns to 1 the cycle after 0x10 leaves.
- Flush while FULL, with simultaneous f_ex_valid=1 and pc=0x20 -> next cycle t_mem_valid=0, t_mem_control=0, and 0x20 is never delivered.
- Counter saturation: CNT_W=4, 20 stall cycles -> t_stall_cnt=15 and holds; flush leaves it at 15.
